// File: rtl/muldiv_unit_if.sv
// Request/response bundle for the RV32M multiply/divide unit.
// The requester owns start/funct3/operands; the unit owns busy/done/result.
interface muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] a_in;
  logic [XLEN-1:0] b_in;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3, a_in, b_in,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3, a_in, b_in,
    output busy, done, result
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: 32 radix-2 steps then a sign fix-up, done 34 edges after start.
// Divide-by-zero and signed overflow bypass the iterations (done 2 edges after start); start ignored while busy.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_unit_if.slave io
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  state_t          state;
  state_t          state_nxt;
  logic [2:0]      op;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] opnd;
  logic            neg_q;
  logic            neg_r;
  logic            special;
  logic [4:0]      cnt;
  logic [XLEN-1:0] result_q;

  logic            accept;
  logic            in_mul;
  logic            in_a_sgn;
  logic            in_b_sgn;
  logic            in_special;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] spec_val;

  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shl;
  logic [XLEN-1:0] hi_nxt;
  logic [XLEN-1:0] lo_nxt;

  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s;
  logic [XLEN-1:0]   rem_s;
  logic [XLEN-1:0]   fix_val;

  assign accept    = io.start && (state == IDLE || state == DONE);
  assign io.busy   = (state == CALC) || (state == FIX);
  assign io.done   = (state == DONE);
  assign io.result = result_q;

  // Operand decode: which operands are treated as signed, their magnitudes,
  // and the architecturally fixed results that need no iteration.
  always_comb begin
    in_mul     = ~io.funct3[2];
    in_a_sgn   = 1'b0;
    in_b_sgn   = 1'b0;
    in_special = 1'b0;
    spec_val   = '0;
    if (in_mul) begin
      in_a_sgn = (io.funct3[1:0] == 2'b01 || io.funct3[1:0] == 2'b10) && io.a_in[XLEN-1];
      in_b_sgn = (io.funct3[1:0] == 2'b01) && io.b_in[XLEN-1];
    end else begin
      in_a_sgn = ~io.funct3[0] && io.a_in[XLEN-1];
      in_b_sgn = ~io.funct3[0] && io.b_in[XLEN-1];
      if (io.b_in == '0) begin
        in_special = 1'b1;
        spec_val   = io.funct3[1] ? io.a_in : ALL_ONE;
      end else if (~io.funct3[0] && io.a_in == MIN_NEG && io.b_in == ALL_ONE) begin
        in_special = 1'b1;
        spec_val   = io.funct3[1] ? '0 : MIN_NEG;
      end
    end
    a_mag = in_a_sgn ? -io.a_in : io.a_in;
    b_mag = in_b_sgn ? -io.b_in : io.b_in;
  end

  // One radix-2 step. Multiply: acc_lo holds the multiplier and shifts product
  // bits in from the top. Divide: acc_lo holds the dividend and collects quotient bits.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_shl = {acc_hi, acc_lo[XLEN-1]};
    if (~op[2]) begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], acc_lo[XLEN-1:1]};
    end else if (div_shl >= {1'b0, opnd}) begin
      hi_nxt = div_shl[XLEN-1:0] - opnd;
      lo_nxt = {acc_lo[XLEN-2:0], 1'b1};
    end else begin
      hi_nxt = div_shl[XLEN-1:0];
      lo_nxt = {acc_lo[XLEN-2:0], 1'b0};
    end
  end

  always_comb begin
    prod   = {acc_hi, acc_lo};
    prod_s = neg_q ? -prod : prod;
    quo_s  = neg_q ? -acc_lo : acc_lo;
    rem_s  = neg_r ? -acc_hi : acc_hi;
    case (op)
      3'b000:                 fix_val = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_val = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fix_val = quo_s;
      default:                fix_val = rem_s;
    endcase
    if (special) fix_val = acc_lo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = in_special ? FIX : CALC;
      CALC: if (cnt == 5'd31) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = accept ? (in_special ? FIX : CALC) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op       <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      special  <= 1'b0;
      cnt      <= '0;
      result_q <= '0;
    end else if (accept) begin
      op      <= io.funct3;
      cnt     <= '0;
      special <= in_special;
      neg_q   <= in_a_sgn ^ in_b_sgn;
      neg_r   <= in_a_sgn;
      acc_hi  <= '0;
      if (in_special) begin
        acc_lo <= spec_val;
        opnd   <= '0;
      end else if (in_mul) begin
        acc_lo <= b_mag;
        opnd   <= a_mag;
      end else begin
        acc_lo <= a_mag;
        opnd   <= b_mag;
      end
    end else if (state == CALC) begin
      acc_hi <= hi_nxt;
      acc_lo <= lo_nxt;
      cnt    <= cnt + 5'd1;
    end else if (state == FIX) begin
      result_q <= fix_val;
    end
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is required to work.
REQ-002 Port: clk  input  1  rising-edge clock for all state.
REQ-003 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port: start  input  1  request to begin an operation; sampled on rising clk.
REQ-005 Port: funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: a_in  input  XLEN  rs1 operand, driven from register_array a_bus.
REQ-007 Port: b_in  input  XLEN  rs2 operand, driven from register_array b_bus.
REQ-008 Port: busy  output  1  high while an accepted operation is in progress.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: result  output  XLEN  operation result, intended for register_array store_value.

Function
REQ-011 States SHALL be IDLE, CALC, FIX, DONE; busy = (state is CALC or FIX); done = (state is DONE).
REQ-012 start SHALL be accepted only when busy=0 (IDLE or DONE); funct3, a_in, b_in are captured at the accepting edge N.
REQ-013 start while busy=1 SHALL be ignored; captured operands and funct3 are unaffected.
REQ-014 Normal path: edge N -> CALC; one radix-2 iteration per edge N+1..N+32 (5-bit counter); edge N+32 -> FIX; edge N+33 -> DONE.
REQ-015 done SHALL be high exactly the one cycle after edge N+33, then state returns to IDLE unless a new start is accepted in that cycle.
REQ-016 Multiply SHALL use unsigned shift-add on operand magnitudes with a 64-bit product; FIX applies sign per funct3 (MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned).
REQ-017 MUL SHALL return product[31:0]; MULH/MULHSU/MULHU SHALL return product[63:32].
REQ-018 Divide SHALL use restoring division on magnitudes; quotient sign = sign(a) XOR sign(b); remainder sign = sign(a) for signed ops.
REQ-019 Divide by zero (b_in=0): DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return a_in.
REQ-020 Signed overflow (DIV/REM, a_in=0x80000000, b_in=0xFFFFFFFF): DIV SHALL return 0x80000000; REM SHALL return 0.
REQ-021 Special cases of REQ-019/020 SHALL skip CALC: edge N -> FIX, edge N+1 -> DONE; done high the cycle after edge N+1.
REQ-022 result SHALL update only on entry to DONE and hold until the next entry to DONE or reset.
REQ-023 A start accepted in the DONE cycle SHALL begin a new operation with no idle gap.

Reset
REQ-024 reset_n low SHALL immediately force state IDLE, busy=0, done=0, result=0, counter=0, internal accumulators=0, independent of clk.
REQ-025 Reset asserted mid-operation SHALL abandon the operation; no done pulse follows deassertion.
REQ-026 First start SHALL be accepted on the first rising clk with reset_n high.

Verification
REQ-027 Reset: hold reset_n=0, toggle start -> busy=0, done=0, result=0x00000000 throughout.
REQ-028 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, done exactly one cycle, after edge N+33; MULH 0x80000000*0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-029 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 0x0000000E; REMU 100/7 -> 0x00000002.
REQ-030 Special: DIVU 5/0 -> 0xFFFFFFFF, REM 5/0 -> 0x00000005, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM same -> 0; each with done after edge N+1.
REQ-031 Busy/overlap: start MUL 3*4, pulse start with DIVU 9/3 at N+10 -> only one done (result 0x0000000C); start DIVU 9/3 in the DONE cycle -> 0x00000003 after a further 34 edges.
REQ-032 Reset mid-op: start DIV 100/7, drop reset_n at N+15 for one cycle -> no done, result=0; subsequent MUL 2*3 -> 0x00000006.
